contador_hv_vga: RTL and testbench

Parametrised horizontal/vertical timing generator for the VGA output path. It replaces the fixed 1600-count horizontal counter with a divided pixel tick, horizontal and vertical counters, sync pulses with programmable polarity, a video-active flag and line/frame strobes. It sits between the board clock and the pixel/character renderer, which consumes `hcount`, `vcount`, `video_on` and `pixel_tick`.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/contador_mod.sv | 45 ++++
 rtl/contador_hv_vga.sv | 109 ++++++++++
 tb/tb_contador_hv_vga.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// VGA timing package: default 640x480@60 constants, sync polarities and the
// total/width derivation shared by the timing generator and the renderer.
package vga_timing_pkg;

  // Default 640x480@60 horizontal timing, in pixels
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;

  // Default 640x480@60 vertical timing, in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  // Board clock cycles per pixel for the default mode
  localparam int VGA_CLK_DIV  = 2;

  // Sync pulse polarities (value driven while the pulse is active)
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // Total counts per line or frame from the four timing segments
  function automatic int timing_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

  // Counter width for a modulo-n count, never narrower than one bit
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/contador_mod.sv
// Generic modulo-N counter with count enable and a wrap strobe that is high
// on the enabled cycle in which the count returns to zero.
module contador_mod
  import vga_timing_pkg::*;
#(
  parameter  int N = 2,
  localparam int W = count_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_next;

  // Next count and terminal-count strobe; the count holds while disabled
  always_comb begin
    wrap       = 1'b0;
    count_next = count;
    if (en) begin
      if (count == LAST) begin
        wrap       = 1'b1;
        count_next = '0;
      end else begin
        count_next = count + W'(1);
      end
    end else begin
      count_next = count;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/contador_hv_vga.sv
// VGA horizontal/vertical timing generator: prescaled pixel tick, pixel and
// line counters, polarity-programmable sync pulses, video-active flag and
// line/frame strobes. Sync and video flags are decoded from the next counter
// values so they update on the same edge as the counters.
module contador_hv_vga
  import vga_timing_pkg::*;
#(
  parameter  int H_ACTIVE = VGA_H_ACTIVE,
  parameter  int H_FRONT  = VGA_H_FRONT,
  parameter  int H_SYNC   = VGA_H_SYNC,
  parameter  int H_BACK   = VGA_H_BACK,
  parameter  int V_ACTIVE = VGA_V_ACTIVE,
  parameter  int V_FRONT  = VGA_V_FRONT,
  parameter  int V_SYNC   = VGA_V_SYNC,
  parameter  int V_BACK   = VGA_V_BACK,
  parameter  bit HS_POL   = SYNC_ACTIVE_LOW,
  parameter  bit VS_POL   = SYNC_ACTIVE_LOW,
  parameter  int CLK_DIV  = VGA_CLK_DIV,
  localparam int H_TOTAL  = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK),
  localparam int V_TOTAL  = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK),
  localparam int HW       = count_width(H_TOTAL),
  localparam int VW       = count_width(V_TOTAL)
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          enable,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          pixel_tick,
  output logic          line_end,
  output logic          frame_end
);

  localparam int DW       = count_width(CLK_DIV);
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  // Prescaler phase: only its wrap strobe is consumed here
  logic [DW-1:0] div_unused;
  logic          div_wrap;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;

  contador_mod #(.N(CLK_DIV)) u_prescaler (
    .clk   (Clk),
    .rst_n (reset),
    .en    (enable),
    .count (div_unused),
    .wrap  (div_wrap)
  );

  // With CLK_DIV=1 the prescaler wrap follows enable, so hold it off in reset
  assign pixel_tick = div_wrap & reset;

  contador_mod #(.N(H_TOTAL)) u_hcount (
    .clk   (Clk),
    .rst_n (reset),
    .en    (pixel_tick),
    .count (hcount),
    .wrap  (line_end)
  );

  contador_mod #(.N(V_TOTAL)) u_vcount (
    .clk   (Clk),
    .rst_n (reset),
    .en    (line_end),
    .count (vcount),
    .wrap  (frame_end)
  );

  // Counter values after the coming edge, so the decodes land with them
  always_comb begin
    h_next = hcount;
    v_next = vcount;
    if (line_end) begin
      h_next = '0;
    end else if (pixel_tick) begin
      h_next = hcount + HW'(1);
    end else begin
      h_next = hcount;
    end
    if (frame_end) begin
      v_next = '0;
    end else if (line_end) begin
      v_next = vcount + VW'(1);
    end else begin
      v_next = vcount;
    end
  end

  // Registered sync and video-active decodes; reset value is the decode of (0,0)
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      hsync    <= ~HS_POL;
      vsync    <= ~VS_POL;
      video_on <= 1'b1;
    end else begin
      hsync    <= (int'(h_next) >= HS_START && int'(h_next) < HS_END) ? HS_POL : ~HS_POL;
      vsync    <= (int'(v_next) >= VS_START && int'(v_next) < VS_END) ? VS_POL : ~VS_POL;
      video_on <= (int'(h_next) < H_ACTIVE) && (int'(v_next) < V_ACTIVE);
    end
  end

endmodule

// File: tb/tb_contador_hv_vga.sv
// Directed bench for contador_hv_vga: default 640x480 timing, an 800x600
// active-high variant with CLK_DIV=1, and a tiny mode whose whole frame fits
// in a few hundred cycles.
module tb_contador_hv_vga;

  typedef struct packed {
    int   hc;
    int   vc;
    logic hs;
    logic vs;
    logic vo;
    logic pt;
    logic le;
    logic fe;
  } exp_t;

  logic Clk = 1'b0;
  logic reset;
  logic enable;

  logic [9:0]  d_hcount;
  logic [9:0]  d_vcount;
  logic        d_hsync, d_vsync, d_video_on, d_pixel_tick, d_line_end, d_frame_end;
  logic [10:0] a_hcount;
  logic [9:0]  a_vcount;
  logic        a_hsync, a_vsync, a_video_on, a_pixel_tick, a_line_end, a_frame_end;
  logic [3:0]  s_hcount;
  logic [3:0]  s_vcount;
  logic        s_hsync, s_vsync, s_video_on, s_pixel_tick, s_line_end, s_frame_end;

  int checks    = 0;
  int passed    = 0;
  int run_edges = 0;
  int cyc       = 0;

  always #5 Clk = ~Clk;

  contador_hv_vga dut_d (
    .Clk(Clk), .reset(reset), .enable(enable),
    .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
    .video_on(d_video_on), .pixel_tick(d_pixel_tick), .line_end(d_line_end),
    .frame_end(d_frame_end)
  );

  contador_hv_vga #(
    .H_ACTIVE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
    .V_ACTIVE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)
  ) dut_a (
    .Clk(Clk), .reset(reset), .enable(enable),
    .hcount(a_hcount), .vcount(a_vcount), .hsync(a_hsync), .vsync(a_vsync),
    .video_on(a_video_on), .pixel_tick(a_pixel_tick), .line_end(a_line_end),
    .frame_end(a_frame_end)
  );

  contador_hv_vga #(
    .H_ACTIVE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(3)
  ) dut_s (
    .Clk(Clk), .reset(reset), .enable(enable),
    .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
    .video_on(s_video_on), .pixel_tick(s_pixel_tick), .line_end(s_line_end),
    .frame_end(s_frame_end)
  );

  // Closed-form timing: n = edges counted since release while enabled
  function automatic exp_t model(int n, int dv, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb,
                                 logic hp, logic vp, logic en);
    exp_t e;
    int ht = ha + hf + hsw + hb;
    int vt = va + vf + vsw + vb;
    e.hc = (n / dv) % ht;
    e.vc = (n / (dv * ht)) % vt;
    e.hs = (e.hc >= ha + hf && e.hc < ha + hf + hsw) ? hp : ~hp;
    e.vs = (e.vc >= va + vf && e.vc < va + vf + vsw) ? vp : ~vp;
    e.vo = (e.hc < ha) && (e.vc < va);
    e.pt = en && ((n % dv) == dv - 1);
    e.le = e.pt && (e.hc == ht - 1);
    e.fe = e.le && (e.vc == vt - 1);
    return e;
  endfunction

  function automatic exp_t exp_d(int n, logic en);
    return model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, en);
  endfunction

  function automatic exp_t exp_a(int n, logic en);
    return model(n, 1, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, en);
  endfunction

  function automatic exp_t exp_s(int n, logic en);
    return model(n, 3, 10, 2, 3, 1, 6, 1, 2, 2, 1'b0, 1'b1, en);
  endfunction

  function automatic exp_t sample_d();
    exp_t o;
    o.hc = int'(d_hcount); o.vc = int'(d_vcount);
    o.hs = d_hsync; o.vs = d_vsync; o.vo = d_video_on;
    o.pt = d_pixel_tick; o.le = d_line_end; o.fe = d_frame_end;
    return o;
  endfunction

  function automatic exp_t sample_a();
    exp_t o;
    o.hc = int'(a_hcount); o.vc = int'(a_vcount);
    o.hs = a_hsync; o.vs = a_vsync; o.vo = a_video_on;
    o.pt = a_pixel_tick; o.le = a_line_end; o.fe = a_frame_end;
    return o;
  endfunction

  function automatic exp_t sample_s();
    exp_t o;
    o.hc = int'(s_hcount); o.vc = int'(s_vcount);
    o.hs = s_hsync; o.vs = s_vsync; o.vo = s_video_on;
    o.pt = s_pixel_tick; o.le = s_line_end; o.fe = s_frame_end;
    return o;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("hc=%0d vc=%0d hs=%0b vs=%0b vo=%0b pt=%0b le=%0b fe=%0b",
                     e.hc, e.vc, e.hs, e.vs, e.vo, e.pt, e.le, e.fe);
  endfunction

  // One clock edge, sampled 1 time unit later
  task automatic step();
    @(posedge Clk);
    cyc++;
    if (enable === 1'b1 && reset === 1'b1) run_edges++;
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b1;
    step();
    step();
    checks++; if (d_hcount !== 10'd0) $display("FAIL reset_d_hcount got %0d want 0", d_hcount); else passed++;
    checks++; if (d_vcount !== 10'd0) $display("FAIL reset_d_vcount got %0d want 0", d_vcount); else passed++;
    checks++; if (d_hsync !== 1'b1) $display("FAIL reset_d_hsync got %b want 1", d_hsync); else passed++;
    checks++; if (d_vsync !== 1'b1) $display("FAIL reset_d_vsync got %b want 1", d_vsync); else passed++;
    checks++; if (d_video_on !== 1'b1) $display("FAIL reset_d_video_on got %b want 1", d_video_on); else passed++;
    checks++; if ({d_pixel_tick, d_line_end, d_frame_end} !== 3'b000)
      $display("FAIL reset_d_strobes got %b want 000", {d_pixel_tick, d_line_end, d_frame_end}); else passed++;
    checks++; if ({a_pixel_tick, a_hsync, a_vsync} !== 3'b000)
      $display("FAIL reset_a_tick_syncs got %b want 000", {a_pixel_tick, a_hsync, a_vsync}); else passed++;
    checks++; if ({s_hsync, s_vsync, s_video_on} !== 3'b101)
      $display("FAIL reset_s_syncs got %b want 101", {s_hsync, s_vsync, s_video_on}); else passed++;
    reset     = 1'b1;
    run_edges = 0;
  endtask

  task automatic test_prescaler();
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++; if (d_pixel_tick !== ((k % 2) == 1))
        $display("FAIL presc_d_tick k=%0d got %b want %b", k, d_pixel_tick, ((k % 2) == 1)); else passed++;
      checks++; if (int'(d_hcount) !== k / 2)
        $display("FAIL presc_d_hcount k=%0d got %0d want %0d", k, d_hcount, k / 2); else passed++;
      checks++; if (a_pixel_tick !== 1'b1 || int'(a_hcount) !== k)
        $display("FAIL presc_a k=%0d got tick=%b hc=%0d want tick=1 hc=%0d", k, a_pixel_tick, a_hcount, k); else passed++;
      checks++; if (s_pixel_tick !== ((k % 3) == 2) || int'(s_hcount) !== k / 3)
        $display("FAIL presc_s k=%0d got tick=%b hc=%0d want tick=%b hc=%0d",
                 k, s_pixel_tick, s_hcount, ((k % 3) == 2), k / 3); else passed++;
    end
  endtask

  task automatic test_small_frame();
    exp_t e, o;
    int lines = 0, frames = 0, fe_at = -1, vs_high = 0;
    for (int k = 0; k < 528; k++) begin
      step();
      e = exp_s(run_edges, 1'b1);
      o = sample_s();
      checks++; if (o !== e) $display("FAIL frame_s n=%0d got %s want %s", run_edges, fmt(o), fmt(e)); else passed++;
      if (s_line_end === 1'b1) lines++;
      if (s_frame_end === 1'b1) begin frames++; fe_at = run_edges; end
      if (s_vsync === 1'b1) vs_high++;
    end
    checks++; if (lines !== 11) $display("FAIL frame_s_lines got %0d want 11", lines); else passed++;
    checks++; if (frames !== 1 || fe_at !== 527)
      $display("FAIL frame_s_frame_end got count=%0d at=%0d want count=1 at=527", frames, fe_at); else passed++;
    checks++; if (vs_high !== 96) $display("FAIL frame_s_vsync_cycles got %0d want 96", vs_high); else passed++;
  endtask

  task automatic test_h_decode();
    exp_t e, o;
    int le_first = -1, le_second = -1, hs_low = 0;
    while (run_edges < 3300) begin
      step();
      e = exp_d(run_edges, 1'b1);
      o = sample_d();
      checks++; if (o !== e) $display("FAIL hdec_d n=%0d got %s want %s", run_edges, fmt(o), fmt(e)); else passed++;
      if (d_line_end === 1'b1) begin
        if (le_first < 0) le_first = run_edges;
        else if (le_second < 0) le_second = run_edges;
      end
      if (d_hsync === 1'b0) hs_low++;
      case (run_edges)
        1279: begin checks++; if (d_hcount !== 10'd639 || d_video_on !== 1'b1)
          $display("FAIL hdec_vo_639 got hc=%0d vo=%b want hc=639 vo=1", d_hcount, d_video_on); else passed++; end
        1280: begin checks++; if (d_hcount !== 10'd640 || d_video_on !== 1'b0)
          $display("FAIL hdec_vo_640 got hc=%0d vo=%b want hc=640 vo=0", d_hcount, d_video_on); else passed++; end
        1599: begin checks++; if (d_hcount !== 10'd799 || d_line_end !== 1'b1)
          $display("FAIL hdec_wrap_799 got hc=%0d le=%b want hc=799 le=1", d_hcount, d_line_end); else passed++; end
        1600: begin checks++; if (d_hcount !== 10'd0 || d_vcount !== 10'd1 || d_video_on !== 1'b1)
          $display("FAIL hdec_wrap_0 got hc=%0d vc=%0d vo=%b want 0 1 1", d_hcount, d_vcount, d_video_on); else passed++; end
        default: ;
      endcase
    end
    checks++; if (le_first !== 1599 || le_second - le_first !== 1600)
      $display("FAIL hdec_line_period got first=%0d period=%0d want 1599 1600", le_first, le_second - le_first); else passed++;
    checks++; if (hs_low !== 384) $display("FAIL hdec_hsync_low got %0d want 384", hs_low); else passed++;
  endtask

  task automatic test_enable();
    exp_t e, o;
    int budget = 0;
    int c0;
    while (d_line_end !== 1'b1 && budget < 2000) begin step(); budget++; end
    checks++; if (d_line_end !== 1'b1) $display("FAIL enable_wait_line_end got timeout want line_end"); else passed++;
    c0 = cyc;
    budget = 0;
    step();
    while (d_hcount !== 10'd300 && budget < 1000) begin step(); budget++; end
    checks++; if (d_hcount !== 10'd300) $display("FAIL enable_wait_h300 got %0d want 300", d_hcount); else passed++;
    enable = 1'b0;
    for (int k = 0; k < 37; k++) begin
      step();
      e = exp_d(run_edges, 1'b0); o = sample_d();
      checks++; if (o !== e) $display("FAIL freeze_d k=%0d got %s want %s", k, fmt(o), fmt(e)); else passed++;
      e = exp_a(run_edges, 1'b0); o = sample_a();
      checks++; if (o !== e) $display("FAIL freeze_a k=%0d got %s want %s", k, fmt(o), fmt(e)); else passed++;
      e = exp_s(run_edges, 1'b0); o = sample_s();
      checks++; if (o !== e) $display("FAIL freeze_s k=%0d got %s want %s", k, fmt(o), fmt(e)); else passed++;
    end
    enable = 1'b1;
    budget = 0;
    step();
    while (d_line_end !== 1'b1 && budget < 2000) begin step(); budget++; end
    checks++; if (cyc - c0 !== 1637) $display("FAIL enable_line_late got %0d cycles want 1637", cyc - c0); else passed++;
  endtask

  task automatic test_reset_midframe();
    exp_t e, o;
    int budget = 0;
    while (d_hcount !== 10'd700 && budget < 2000) begin step(); budget++; end
    checks++; if (d_hcount !== 10'd700 || d_vcount !== 10'd4 || s_vsync !== 1'b1)
      $display("FAIL midrst_pre got hc=%0d vc=%0d s_vs=%b want 700 4 1", d_hcount, d_vcount, s_vsync); else passed++;
    #3;
    reset = 1'b0;
    #1;
    checks++; if (d_hcount !== 10'd0 || d_vcount !== 10'd0)
      $display("FAIL midrst_d_counts got hc=%0d vc=%0d want 0 0", d_hcount, d_vcount); else passed++;
    checks++; if ({d_hsync, d_vsync, d_video_on, d_pixel_tick, d_line_end, d_frame_end} !== 6'b111000)
      $display("FAIL midrst_d_flags got %b want 111000",
               {d_hsync, d_vsync, d_video_on, d_pixel_tick, d_line_end, d_frame_end}); else passed++;
    checks++; if (a_hcount !== 11'd0 || {a_hsync, a_vsync, a_pixel_tick} !== 3'b000)
      $display("FAIL midrst_a got hc=%0d flags=%b want 0 000", a_hcount, {a_hsync, a_vsync, a_pixel_tick}); else passed++;
    checks++; if (s_vcount !== 4'd0 || {s_hsync, s_vsync, s_video_on} !== 3'b101)
      $display("FAIL midrst_s got vc=%0d flags=%b want 0 101", s_vcount, {s_hsync, s_vsync, s_video_on}); else passed++;
    run_edges = 0;
    step(); step(); step();
    checks++; if (d_hcount !== 10'd0 || d_pixel_tick !== 1'b0 || a_pixel_tick !== 1'b0)
      $display("FAIL midrst_hold got hc=%0d dtick=%b atick=%b want 0 0 0", d_hcount, d_pixel_tick, a_pixel_tick); else passed++;
    reset = 1'b1;
    step();
    checks++; if (d_hcount !== 10'd0 || d_pixel_tick !== 1'b1 || a_hcount !== 11'd1)
      $display("FAIL midrst_first_edge got dhc=%0d dtick=%b ahc=%0d want 0 1 1", d_hcount, d_pixel_tick, a_hcount); else passed++;
    for (int k = 0; k < 100; k++) begin
      step();
      e = exp_d(run_edges, 1'b1); o = sample_d();
      checks++; if (o !== e) $display("FAIL restart_d n=%0d got %s want %s", run_edges, fmt(o), fmt(e)); else passed++;
      e = exp_s(run_edges, 1'b1); o = sample_s();
      checks++; if (o !== e) $display("FAIL restart_s n=%0d got %s want %s", run_edges, fmt(o), fmt(e)); else passed++;
    end
  endtask

  task automatic test_alt_params();
    exp_t e, o;
    int le_first = -1, le_second = -1, hs_high = 0, tick_low = 0, vs_high = 0;
    while (run_edges < 2300) begin
      step();
      e = exp_a(run_edges, 1'b1);
      o = sample_a();
      checks++; if (o !== e) $display("FAIL alt_a n=%0d got %s want %s", run_edges, fmt(o), fmt(e)); else passed++;
      if (a_line_end === 1'b1) begin
        if (le_first < 0) le_first = run_edges;
        else if (le_second < 0) le_second = run_edges;
      end
      if (a_hsync === 1'b1) hs_high++;
      if (a_vsync === 1'b1) vs_high++;
      if (a_pixel_tick !== 1'b1) tick_low++;
    end
    checks++; if (le_first !== 1055 || le_second - le_first !== 1056)
      $display("FAIL alt_line_period got first=%0d period=%0d want 1055 1056", le_first, le_second - le_first); else passed++;
    checks++; if (hs_high !== 256) $display("FAIL alt_hsync_high got %0d want 256", hs_high); else passed++;
    checks++; if (tick_low !== 0) $display("FAIL alt_tick_low got %0d want 0", tick_low); else passed++;
    checks++; if (vs_high !== 0) $display("FAIL alt_vsync_high got %0d want 0", vs_high); else passed++;
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_small_frame();
    test_h_decode();
    test_enable();
    test_reset_midframe();
    test_alt_params();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion (%0d/%0d checks passed)", passed, checks);
    $fatal(1);
  end

endmodule
